// File: rtl/puf_sweep_ctrl_if.sv
// Handshake between the sweep controller and the ring-oscillator PUF core.
// master: controller side; slave: PUF core side.
interface puf_sweep_ctrl_if;
    logic       reset;
    logic [7:0] challenge;
    logic [7:0] response;
    logic       done;

    modport master (
        output reset,
        output challenge,
        input  response,
        input  done
    );

    modport slave (
        input  reset,
        input  challenge,
        output response,
        output done
    );
endinterface

// File: rtl/puf_sweep_ctrl.sv
// Challenge sequencer and majority-vote conditioner for the ring-oscillator PUF.
// Walks NUM_CHAL challenges, evaluates each REPEATS times, reports voted responses.
//
// state  | meaning
// IDLE   | waiting for start
// PULSE  | holding PUF reset for RST_CYCLES cycles
// WAIT   | guard cycle, then waiting for PUF done (bounded by TIMEOUT)
// EMIT   | voted result presented for one cycle
// FINISH | sweep_done pulse, then back to IDLE
module puf_sweep_ctrl #(
    parameter int REPEATS    = 5,
    parameter int NUM_CHAL   = 16,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       chal_base,
    puf_sweep_ctrl_if.master puf,
    output logic [7:0]       result,
    output logic [7:0]       result_chal,
    output logic             result_valid,
    output logic [11:0]      unstable,
    output logic             sweep_done,
    output logic             busy,
    output logic             error
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT,
        EMIT,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   rst_tmr;
    logic [TW-1:0]   wait_tmr;
    logic [7:0][3:0] ones;
    logic [7:0][3:0] ones_upd;
    logic [3:0]      rep;
    logic [3:0]      rep_upd;
    logic [7:0]      chal;
    logic [8:0]      chal_idx;
    logic            capture;
    logic            timeout;
    logic            guard;
    logic [7:0]      vote;
    logic [3:0]      n_unst;
    logic [12:0]     unst_sum;
    logic [11:0]     unst_sat;

    // Timers preload while outside their state, so entry always sees a full count.
    assign guard    = (wait_tmr == TW'(TIMEOUT - 1));
    assign unst_sum = {1'b0, unstable} + {9'd0, n_unst};
    assign unst_sat = unst_sum[12] ? 12'hFFF : unst_sum[11:0];

    assign puf.challenge = chal;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        timeout   = 1'b0;
        ones_upd  = ones;
        rep_upd   = rep;
        vote      = '0;
        n_unst    = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                if (rst_tmr == '0) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!guard && puf.done) begin
                    capture = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        ones_upd[i] = ones[i] + {3'b000, puf.response[i]};
                    end
                    rep_upd   = rep + 4'd1;
                    state_nxt = (rep_upd == 4'(REPEATS)) ? EMIT : PULSE;
                end else if (wait_tmr == '0) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            EMIT: begin
                state_nxt = (chal_idx == 9'(NUM_CHAL)) ? FINISH : PULSE;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        for (int i = 0; i < 8; i++) begin
            vote[i] = ({ones_upd[i], 1'b0} > 5'(REPEATS));
            if ((ones_upd[i] != 4'd0) && (ones_upd[i] != 4'(REPEATS))) begin
                n_unst = n_unst + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rst_tmr      <= RW'(RST_CYCLES - 1);
            wait_tmr     <= TW'(TIMEOUT - 1);
            ones         <= '0;
            rep          <= '0;
            chal         <= '0;
            chal_idx     <= '0;
            puf.reset    <= 1'b0;
            result       <= '0;
            result_chal  <= '0;
            result_valid <= 1'b0;
            unstable     <= '0;
            sweep_done   <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            rst_tmr      <= (state == PULSE) ? rst_tmr - 1'b1 : RW'(RST_CYCLES - 1);
            wait_tmr     <= (state == WAIT) ? wait_tmr - 1'b1 : TW'(TIMEOUT - 1);
            puf.reset    <= (state_nxt == PULSE);
            busy         <= (state_nxt != IDLE);
            result_valid <= (state_nxt == EMIT);
            sweep_done   <= (state_nxt == FINISH);

            if ((state == IDLE) && start) begin
                chal     <= chal_base;
                chal_idx <= '0;
                rep      <= '0;
                ones     <= '0;
                unstable <= '0;
                error    <= 1'b0;
            end

            // The last capture of a challenge folds straight into the emitted result,
            // so the challenge advances as EMIT begins.
            if (capture) begin
                if (state_nxt == EMIT) begin
                    result      <= vote;
                    result_chal <= chal;
                    unstable    <= unst_sat;
                    chal        <= chal + 8'd1;
                    chal_idx    <= chal_idx + 9'd1;
                    ones        <= '0;
                    rep         <= '0;
                end else begin
                    ones <= ones_upd;
                    rep  <= rep_upd;
                end
            end

            if (timeout) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_puf_sweep_ctrl.sv
// Directed bench for puf_sweep_ctrl: table of sweep vectors plus timeout,
// mid-sweep reset and start-while-busy sequences against a behavioural PUF.
module tb_puf_sweep_ctrl;
    localparam int REP  = 5;
    localparam int NCH  = 4;
    localparam int RSTC = 2;
    localparam int TO   = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  chal_base = 8'h00;
    logic [7:0]  result;
    logic [7:0]  result_chal;
    logic        result_valid;
    logic [11:0] unstable;
    logic        sweep_done;
    logic        busy;
    logic        error;

    puf_sweep_ctrl_if pufif ();

    puf_sweep_ctrl #(
        .REPEATS    (REP),
        .NUM_CHAL   (NCH),
        .RST_CYCLES (RSTC),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .start        (start),
        .chal_base    (chal_base),
        .puf          (pufif),
        .result       (result),
        .result_chal  (result_chal),
        .result_valid (result_valid),
        .unstable     (unstable),
        .sweep_done   (sweep_done),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      base;
        logic [0:4][7:0] pat;
        logic            hold;
        logic            poke;
        logic [7:0]      exp_res;
        logic [11:0]     exp_unst;
    } vec_t;

    // PUF model: response pattern indexed by evaluation number within the sweep.
    logic            hold = 1'b0;
    logic            stuck = 1'b0;
    logic [0:4][7:0] model_pat = '0;
    int              ev = -1;
    int              cnt = 0;
    logic            prev_rst = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!busy) ev = -1;
        else if (pufif.reset && !prev_rst) ev = ev + 1;
        prev_rst = pufif.reset;
        if (ev >= 0) pufif.response = model_pat[ev % 5];
        else pufif.response = 8'h00;
        if (stuck) pufif.done = 1'b0;
        else if (hold) pufif.done = 1'b1;
        else if (pufif.reset) begin
            cnt = 0;
            pufif.done = 1'b0;
        end else begin
            if (cnt < 1000) cnt = cnt + 1;
            pufif.done = (cnt >= 10);
        end
    end

    // Monitor: result log, reset-pulse statistics, challenge stability.
    int          n_valid = 0;
    int          n_rise = 0;
    int          bad_pulse = 0;
    int          n_sd = 0;
    int          chal_viol = 0;
    int          plen = 0;
    logic [15:0] res_log [0:1023];
    logic [11:0] last_unst = '0;
    logic        prev_busy = 1'b0;
    logic        prev_pr = 1'b0;
    logic [7:0]  prev_ch = '0;

    always @(negedge clk) begin
        if (result_valid) begin
            res_log[n_valid % 1024] = {result_chal, result};
            n_valid = n_valid + 1;
        end
        if (sweep_done) begin
            n_sd = n_sd + 1;
            last_unst = unstable;
        end
        if (pufif.reset) begin
            if (!prev_pr) n_rise = n_rise + 1;
            plen = plen + 1;
        end else if (prev_pr) begin
            if (plen != RSTC) bad_pulse = bad_pulse + 1;
            plen = 0;
        end
        if (busy && prev_busy && (pufif.challenge != prev_ch) && !result_valid)
            chal_viol = chal_viol + 1;
        prev_busy = busy;
        prev_pr   = pufif.reset;
        prev_ch   = pufif.challenge;
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_puf_reset"}, pufif.reset, 0);
        chk({pfx, "_puf_challenge"}, pufif.challenge, 0);
        chk({pfx, "_result"}, result, 0);
        chk({pfx, "_result_chal"}, result_chal, 0);
        chk({pfx, "_result_valid"}, result_valid, 0);
        chk({pfx, "_unstable"}, unstable, 0);
        chk({pfx, "_sweep_done"}, sweep_done, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_error"}, error, 0);
    endtask

    task automatic do_start(input logic [7:0] base);
        @(negedge clk);
        chal_base = base;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int nv0, nr0, bp0, sd0, cv0, n;
        logic seen;
        nv0 = n_valid; nr0 = n_rise; bp0 = bad_pulse; sd0 = n_sd; cv0 = chal_viol;
        stuck = 1'b0;
        hold = v.hold;
        model_pat = v.pat;
        do_start(v.base);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n = n + 1;
            if (v.poke && n == 30) begin
                chal_base = 8'h55;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (sweep_done) seen = 1'b1;
        end
        start = 1'b0;
        chk($sformatf("v%0d_sweep_done_seen", id), seen, 1);
        @(negedge clk);
        chk($sformatf("v%0d_busy_after", id), busy, 0);
        chk($sformatf("v%0d_error", id), error, 0);
        chk($sformatf("v%0d_n_valid", id), n_valid - nv0, NCH);
        chk($sformatf("v%0d_n_sweep_done", id), n_sd - sd0, 1);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("v%0d_result_%0d", id, k), res_log[(nv0 + k) % 1024][7:0], v.exp_res);
            chk($sformatf("v%0d_result_chal_%0d", id, k), res_log[(nv0 + k) % 1024][15:8],
                8'(v.base + 8'(k)));
        end
        chk($sformatf("v%0d_unstable", id), last_unst, v.exp_unst);
        chk($sformatf("v%0d_puf_reset_pulses", id), n_rise - nr0, NCH * REP);
        chk($sformatf("v%0d_bad_pulse_len", id), bad_pulse - bp0, 0);
        chk($sformatf("v%0d_chal_changed_mid_eval", id), chal_viol - cv0, 0);
        if (v.hold)
            chk($sformatf("v%0d_sweep_cycles", id), n, NCH * (REP * (RSTC + 2) + 1) + 1);
    endtask

    initial begin
        vec_t vecs [5];
        int   n, nv0, sd0, r0;

        vecs[0] = '{base: 8'h10, pat: {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5},
                    hold: 1'b0, poke: 1'b0, exp_res: 8'hA5, exp_unst: 12'd0};
        vecs[1] = '{base: 8'h20, pat: {8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00},
                    hold: 1'b0, poke: 1'b0, exp_res: 8'hFF, exp_unst: 12'd32};
        vecs[2] = '{base: 8'hFE, pat: {8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'hF0},
                    hold: 1'b0, poke: 1'b0, exp_res: 8'hF0, exp_unst: 12'd32};
        vecs[3] = '{base: 8'h00, pat: {8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F},
                    hold: 1'b1, poke: 1'b1, exp_res: 8'h07, exp_unst: 12'd16};
        vecs[4] = '{base: 8'h80, pat: {8'h80, 8'h00, 8'h00, 8'h00, 8'h00},
                    hold: 1'b0, poke: 1'b0, exp_res: 8'h00, exp_unst: 12'd4};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("por");

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Stuck PUF: expect timeout after TO wait cycles, no result or sweep pulse.
        stuck = 1'b1;
        hold = 1'b0;
        nv0 = n_valid;
        sd0 = n_sd;
        do_start(8'h30);
        n = 0;
        while (!error && n < 500) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("to_latency", n, RSTC + 1 + TO);
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("to_error_sticky", error, 1);
        chk("to_no_valid", n_valid - nv0, 0);
        chk("to_no_sweep_done", n_sd - sd0, 0);
        stuck = 1'b0;

        // Accepted start clears the sticky error.
        run_vec(vecs[1], 5);

        // Reset during the third evaluation.
        hold = 1'b0;
        model_pat = vecs[0].pat;
        r0 = n_rise;
        do_start(8'h10);
        n = 0;
        while ((n_rise - r0) < 3 && n < 500) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("rst_third_eval_reached", ((n_rise - r0) >= 3) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid_rst");
        repeat (3) @(negedge clk);
        chk("mid_rst_stays_idle", busy, 0);

        run_vec(vecs[0], 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
